// File: rtl/sobel_window.sv
// Streaming 3x3 window generator with two line buffers, feeding the Sobel stage.
// Optional window-centre coordinate outputs: define SOBEL_WINDOW_COORD_EN.
module sobel_window #(
    parameter int p_num_bits   = 1,
    parameter int p_img_width  = 320,
    parameter int p_img_height = 240
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic                  in_sof,
    input  logic [p_num_bits-1:0] in_pixel,
    output logic [p_num_bits-1:0] x00,
    output logic [p_num_bits-1:0] x01,
    output logic [p_num_bits-1:0] x02,
    output logic [p_num_bits-1:0] x10,
    output logic [p_num_bits-1:0] x11,
    output logic [p_num_bits-1:0] x12,
    output logic [p_num_bits-1:0] x20,
    output logic [p_num_bits-1:0] x21,
    output logic [p_num_bits-1:0] x22,
    output logic                  out_valid,
    output logic                  out_eof
`ifdef SOBEL_WINDOW_COORD_EN
   ,output logic [$clog2(p_img_height)-1:0] out_row
   ,output logic [$clog2(p_img_width)-1:0]  out_col
`endif
);

    localparam int CW = $clog2(p_img_width);
    localparam int RW = $clog2(p_img_height);
    localparam logic [CW-1:0] C_LAST = CW'(p_img_width - 1);
    localparam logic [RW-1:0] R_LAST = RW'(p_img_height - 1);
    localparam logic [CW-1:0] C_TWO  = CW'(2);
    localparam logic [RW-1:0] R_TWO  = RW'(2);

    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic [CW-1:0] w_col;
    logic [RW-1:0] w_row;
    logic [CW-1:0] w_col_nxt;
    logic [RW-1:0] w_row_nxt;
    logic          w_last_col;
    logic          w_last_row;

    logic [p_num_bits-1:0] r_lb_a [p_img_width];
    logic [p_num_bits-1:0] r_lb_b [p_img_width];
    logic [p_num_bits-1:0] w_lb_a;
    logic [p_num_bits-1:0] w_lb_b;

    logic [2:0][2:0][p_num_bits-1:0] r_win;
    logic                            r_valid;
    logic                            r_eof;

    // A start-of-frame pixel is (0,0) whatever the counters say.
    assign w_col      = in_sof ? '0 : r_col;
    assign w_row      = in_sof ? '0 : r_row;
    assign w_last_col = (w_col == C_LAST);
    assign w_last_row = (w_row == R_LAST);
    assign w_lb_a     = r_lb_a[w_col];
    assign w_lb_b     = r_lb_b[w_col];

    always_comb begin
        w_col_nxt = w_col + CW'(1);
        w_row_nxt = w_row;
        if (w_last_col) begin
            w_col_nxt = '0;
            w_row_nxt = w_last_row ? '0 : w_row + RW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col   <= '0;
            r_row   <= '0;
            r_win   <= '0;
            r_valid <= 1'b0;
            r_eof   <= 1'b0;
        end else begin
            r_valid <= in_valid && (w_row >= R_TWO) && (w_col >= C_TWO);
            r_eof   <= in_valid && w_last_row && w_last_col;
            if (in_valid) begin
                r_col <= w_col_nxt;
                r_row <= w_row_nxt;
                for (int i = 0; i < 3; i++) begin
                    r_win[i][0] <= r_win[i][1];
                    r_win[i][1] <= r_win[i][2];
                end
                r_win[0][2] <= w_lb_a;
                r_win[1][2] <= w_lb_b;
                r_win[2][2] <= in_pixel;
            end
        end
    end

    // Line buffers carry no reset; stale rows are never inside a valid window.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            r_lb_a[w_col] <= w_lb_b;
            r_lb_b[w_col] <= in_pixel;
        end
    end

`ifdef SOBEL_WINDOW_COORD_EN
    logic [RW-1:0] r_out_row;
    logic [CW-1:0] r_out_col;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_row <= '0;
            r_out_col <= '0;
        end else if (in_valid) begin
            r_out_row <= w_row - RW'(1);
            r_out_col <= w_col - CW'(1);
        end
    end

    assign out_row = r_out_row;
    assign out_col = r_out_col;
`endif

    assign x00       = r_win[0][0];
    assign x01       = r_win[0][1];
    assign x02       = r_win[0][2];
    assign x10       = r_win[1][0];
    assign x11       = r_win[1][1];
    assign x12       = r_win[1][2];
    assign x20       = r_win[2][0];
    assign x21       = r_win[2][1];
    assign x22       = r_win[2][2];
    assign out_valid = r_valid;
    assign out_eof   = r_eof;

endmodule

// File: tb/tb_sobel_window.sv
// Directed bench for sobel_window on a 4x4, 8-bit image.
// Window table indexed by the position of the pixel that lands in x22.
module tb_sobel_window;

    localparam int W = 4;
    localparam int H = 4;
    localparam int N = 8;

    logic         clk      = 1'b0;
    logic         rst_n    = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_sof   = 1'b0;
    logic [N-1:0] in_pixel = '0;
    logic [N-1:0] x00, x01, x02, x10, x11, x12, x20, x21, x22;
    logic         out_valid;
    logic         out_eof;
`ifdef SOBEL_WINDOW_COORD_EN
    logic [1:0]   out_row;
    logic [1:0]   out_col;
`endif

    always #5 clk = ~clk;

    sobel_window #(
        .p_num_bits  (N),
        .p_img_width (W),
        .p_img_height(H)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_sof   (in_sof),
        .in_pixel (in_pixel),
        .x00      (x00),
        .x01      (x01),
        .x02      (x02),
        .x10      (x10),
        .x11      (x11),
        .x12      (x12),
        .x20      (x20),
        .x21      (x21),
        .x22      (x22),
        .out_valid(out_valid),
        .out_eof  (out_eof)
`ifdef SOBEL_WINDOW_COORD_EN
       ,.out_row  (out_row)
       ,.out_col  (out_col)
`endif
    );

    wire [71:0] win = {x00, x01, x02, x10, x11, x12, x20, x21, x22};

    typedef struct packed {
        logic [1:0]  r;
        logic [1:0]  c;
        logic [71:0] win;
        logic        eof;
    } vec_t;

    vec_t tbl [4];
    int   nchk   = 0;
    int   nerr   = 0;
    int   nvalid = 0;

    task automatic chk(input string name, input logic [71:0] act,
                       input logic [71:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] pix, input logic sof,
                        input int r, input int c, input logic inv);
        int idx;
        in_valid = 1'b1;
        in_sof   = sof;
        in_pixel = pix;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        if (out_valid) nvalid++;
        chk("valid", {71'd0, out_valid}, {71'd0, (r >= 2 && c >= 2)});
        if (r >= 2 && c >= 2) begin
            idx = (r - 2) * 2 + (c - 2);
            chk("window", win, inv ? ~tbl[idx].win : tbl[idx].win);
            chk("eof", {71'd0, out_eof}, {71'd0, tbl[idx].eof});
`ifdef SOBEL_WINDOW_COORD_EN
            chk("out_row", {70'd0, out_row}, {70'd0, tbl[idx].r - 2'd1});
            chk("out_col", {70'd0, out_col}, {70'd0, tbl[idx].c - 2'd1});
`endif
        end else begin
            chk("eof_low", {71'd0, out_eof}, 72'd0);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            chk("idle_valid", {71'd0, out_valid}, 72'd0);
            chk("idle_eof", {71'd0, out_eof}, 72'd0);
        end
    endtask

    task automatic send_pixels(input int count, input logic inv,
                               input logic gaps);
        logic [7:0] pix;
        for (int p = 0; p < count; p++) begin
            if (gaps) idle($urandom_range(0, 2));
            pix = 8'(4 * (p / W) + (p % W));
            if (inv) pix = 8'd255 - pix;
            push(pix, p == 0, p / W, p % W, inv);
        end
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_win"}, win, 72'd0);
        chk({name, "_valid"}, {71'd0, out_valid}, 72'd0);
        chk({name, "_eof"}, {71'd0, out_eof}, 72'd0);
`ifdef SOBEL_WINDOW_COORD_EN
        chk({name, "_coord"}, {68'd0, out_row, out_col}, 72'd0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{r: 2'd2, c: 2'd2, eof: 1'b0,
                   win: {8'd0, 8'd1, 8'd2, 8'd4, 8'd5, 8'd6, 8'd8, 8'd9, 8'd10}};
        tbl[1] = '{r: 2'd2, c: 2'd3, eof: 1'b0,
                   win: {8'd1, 8'd2, 8'd3, 8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11}};
        tbl[2] = '{r: 2'd3, c: 2'd2, eof: 1'b0,
                   win: {8'd4, 8'd5, 8'd6, 8'd8, 8'd9, 8'd10, 8'd12, 8'd13, 8'd14}};
        tbl[3] = '{r: 2'd3, c: 2'd3, eof: 1'b1,
                   win: {8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11, 8'd13, 8'd14, 8'd15}};

        #12;
        chk_zero("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // back-to-back frame from reset
        nvalid = 0;
        send_pixels(16, 1'b0, 1'b0);
        chk("count_b2b", 72'(nvalid), 72'd4);

        // same frame with random gaps
        nvalid = 0;
        idle(3);
        send_pixels(16, 1'b0, 1'b1);
        idle(2);
        chk("count_gaps", 72'(nvalid), 72'd4);

        // two frames back-to-back, second inverted
        nvalid = 0;
        send_pixels(16, 1'b0, 1'b0);
        send_pixels(16, 1'b1, 1'b0);
        chk("count_two", 72'(nvalid), 72'd8);

        // restart with in_sof at pixel (2,1)
        nvalid = 0;
        send_pixels(9, 1'b0, 1'b0);
        send_pixels(16, 1'b1, 1'b0);
        chk("count_sof", 72'(nvalid), 72'd4);

        // async reset while pixel (3,1) is being presented
        nvalid = 0;
        send_pixels(13, 1'b0, 1'b0);
        in_valid = 1'b1;
        in_pixel = 8'd13;
        #3;
        rst_n = 1'b0;
        #1;
        chk_zero("midreset");
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk_zero("held_reset");
        rst_n = 1'b1;
        nvalid = 0;
        send_pixels(16, 1'b1, 1'b0);
        chk("count_rst", 72'(nvalid), 72'd4);
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
